// File: rtl/load_data_queue_pkg.sv
// Shared sizing constants and the LDQ entry layout for the memory-stage load queue.
package load_data_queue_pkg;

    localparam int LDQ_ENTRIES = 16;
    localparam int SDQ_ENTRIES = 16;
    localparam int LDQ_IDX_W   = $clog2(LDQ_ENTRIES);
    localparam int SDQ_MRK_W   = $clog2(SDQ_ENTRIES) + 1;

    typedef struct packed {
        logic                 vld;
        logic                 addr_vld;
        logic [31:0]          addr;
        logic [SDQ_MRK_W-1:0] sdq_marker;
        logic [LDQ_IDX_W-1:0] ldq_idx;
    } ldq_entry_t;

endpackage

// File: rtl/load_data_queue_ptr.sv
// Circular queue pointer: index bits plus a wrap bit; advances by one when inc is set.
module ldq_ptr #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [IDX_W:0]   ptr_q
);

    logic [IDX_W:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/load_data_queue.sv
// In-order load data queue: program-order allocate, indexed address write, oldest-first issue.
// Build option LDQ_EXEC_BYPASS_EN lets an address written to the waiting head issue in the same cycle.
module load_data_queue
    import load_data_queue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 disp_vld,
    input  logic [SDQ_MRK_W-1:0] disp_sdq_marker,
    output logic [LDQ_IDX_W-1:0] disp_ldq_idx,
    output logic                 disp_full,
    input  logic                 exec_vld,
    input  logic [LDQ_IDX_W-1:0] exec_ldq_idx,
    input  logic [31:0]          exec_addr,
    output ldq_entry_t           issue_entry,
    output logic                 issue_vld
);

    ldq_entry_t           entries_q [LDQ_ENTRIES];
    ldq_entry_t           entries_d [LDQ_ENTRIES];
    logic [LDQ_IDX_W:0]   head_q;
    logic [LDQ_IDX_W:0]   tail_q;
    logic [LDQ_IDX_W-1:0] head_idx;
    logic [LDQ_IDX_W-1:0] tail_idx;
    logic                 disp_fire;
    logic                 exec_hit;
    logic                 head_byp;
    ldq_entry_t           head_ent;

    assign head_idx  = head_q[LDQ_IDX_W-1:0];
    assign tail_idx  = tail_q[LDQ_IDX_W-1:0];
    assign disp_full = (head_idx == tail_idx) && (head_q[LDQ_IDX_W] != tail_q[LDQ_IDX_W]);
    assign disp_ldq_idx = tail_idx;
    assign disp_fire = disp_vld && !disp_full;
    assign head_ent  = entries_q[head_idx];

    // Exec only lands on slots that were already allocated before this edge.
    assign exec_hit = exec_vld && entries_q[exec_ldq_idx].vld;

`ifdef LDQ_EXEC_BYPASS_EN
    assign head_byp = exec_vld && (exec_ldq_idx == head_idx) && head_ent.vld && !head_ent.addr_vld;
`else
    assign head_byp = 1'b0;
`endif

    always_comb begin
        issue_vld   = head_ent.vld && (head_ent.addr_vld || head_byp);
        issue_entry = '0;
        if (issue_vld) begin
            issue_entry = head_ent;
            if (head_byp) begin
                issue_entry.addr     = exec_addr;
                issue_entry.addr_vld = 1'b1;
            end
        end
    end

    // Exec applied before the issue clear so an exec to the popping head leaves it free.
    always_comb begin
        for (int i = 0; i < LDQ_ENTRIES; i++) begin
            entries_d[i] = entries_q[i];
        end
        if (exec_hit) begin
            entries_d[exec_ldq_idx].addr     = exec_addr;
            entries_d[exec_ldq_idx].addr_vld = 1'b1;
        end
        if (issue_vld) begin
            entries_d[head_idx].vld      = 1'b0;
            entries_d[head_idx].addr_vld = 1'b0;
        end
        if (disp_fire) begin
            entries_d[tail_idx].vld        = 1'b1;
            entries_d[tail_idx].addr_vld   = 1'b0;
            entries_d[tail_idx].addr       = '0;
            entries_d[tail_idx].sdq_marker = disp_sdq_marker;
            entries_d[tail_idx].ldq_idx    = tail_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LDQ_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LDQ_ENTRIES; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    ldq_ptr #(.IDX_W(LDQ_IDX_W)) u_head_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (issue_vld),
        .ptr_q (head_q)
    );

    ldq_ptr #(.IDX_W(LDQ_IDX_W)) u_tail_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (disp_fire),
        .ptr_q (tail_q)
    );

endmodule

// File: tb/tb_load_data_queue.sv
// Directed bench for load_data_queue: cycle table plus fill/wrap and ordered-drain sequences.
module tb_load_data_queue;
    import load_data_queue_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 disp_vld = 1'b0;
    logic [SDQ_MRK_W-1:0] disp_sdq_marker = '0;
    logic [LDQ_IDX_W-1:0] disp_ldq_idx;
    logic                 disp_full;
    logic                 exec_vld = 1'b0;
    logic [LDQ_IDX_W-1:0] exec_ldq_idx = '0;
    logic [31:0]          exec_addr = '0;
    ldq_entry_t           issue_entry;
    logic                 issue_vld;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_data_queue dut (
        .clk             (clk),
        .rst             (rst),
        .disp_vld        (disp_vld),
        .disp_sdq_marker (disp_sdq_marker),
        .disp_ldq_idx    (disp_ldq_idx),
        .disp_full       (disp_full),
        .exec_vld        (exec_vld),
        .exec_ldq_idx    (exec_ldq_idx),
        .exec_addr       (exec_addr),
        .issue_entry     (issue_entry),
        .issue_vld       (issue_vld)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input int mk, input logic ev, input int ei, input int ea);
        disp_vld        = dv;
        disp_sdq_marker = SDQ_MRK_W'(mk);
        exec_vld        = ev;
        exec_ldq_idx    = LDQ_IDX_W'(ei);
        exec_addr       = 32'(ea);
    endtask

    typedef struct {
        logic dv; int mk; logic ev; int ei; int ea;
        int   e_idx; logic e_full; logic e_iss; int e_addr; int e_mk; int e_lidx;
    } vec_t;

    vec_t vecs[22];

    initial begin
        // dv mk ev ei ea | idx full iss addr mk lidx  (outputs before the edge)
        vecs[0]  = '{0, 0, 0,  0, 0,      0, 0, 0, 0,     0, 0};
        vecs[1]  = '{0, 0, 0,  0, 0,      0, 0, 0, 0,     0, 0};
        vecs[2]  = '{1, 5, 0,  0, 0,      0, 0, 0, 0,     0, 0};
        vecs[3]  = '{0, 0, 0,  0, 0,      1, 0, 0, 0,     0, 0};
        vecs[4]  = '{0, 0, 1, 15, 5108,   1, 0, 0, 0,     0, 0};
        vecs[5]  = '{0, 0, 0,  0, 0,      1, 0, 0, 0,     0, 0};
        vecs[6]  = '{0, 0, 1,  0, 5108,   1, 0, 0, 0,     0, 0};
        vecs[7]  = '{0, 0, 0,  0, 0,      1, 0, 1, 5108,  5, 0};
        vecs[8]  = '{0, 0, 0,  0, 0,      1, 0, 0, 0,     0, 0};
        vecs[9]  = '{1, 3, 0,  0, 0,      1, 0, 0, 0,     0, 0};
        vecs[10] = '{1, 4, 0,  0, 0,      2, 0, 0, 0,     0, 0};
        vecs[11] = '{0, 0, 1,  2, 'h200,  3, 0, 0, 0,     0, 0};
        vecs[12] = '{0, 0, 0,  0, 0,      3, 0, 0, 0,     0, 0};
        vecs[13] = '{0, 0, 1,  1, 'h100,  3, 0, 0, 0,     0, 0};
        vecs[14] = '{0, 0, 0,  0, 0,      3, 0, 1, 'h100, 3, 1};
        vecs[15] = '{0, 0, 0,  0, 0,      3, 0, 1, 'h200, 4, 2};
        vecs[16] = '{0, 0, 0,  0, 0,      3, 0, 0, 0,     0, 0};
        vecs[17] = '{1, 7, 1,  3, 'h300,  3, 0, 0, 0,     0, 0};
        vecs[18] = '{0, 0, 0,  0, 0,      4, 0, 0, 0,     0, 0};
        vecs[19] = '{0, 0, 1,  3, 'h333,  4, 0, 0, 0,     0, 0};
        vecs[20] = '{1, 1, 0,  0, 0,      4, 0, 1, 'h333, 7, 3};
        vecs[21] = '{0, 0, 0,  0, 0,      5, 0, 0, 0,     0, 0};

        #2;
        chk("rst_idx", 64'(disp_ldq_idx), 0);
        chk("rst_full", 64'(disp_full), 0);
        chk("rst_issue_vld", 64'(issue_vld), 0);
        chk("rst_issue_entry", 64'(issue_entry), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(vecs[i].dv, vecs[i].mk, vecs[i].ev, vecs[i].ei, vecs[i].ea);
            #1;
            chk($sformatf("v%0d_idx", i), 64'(disp_ldq_idx), 64'(vecs[i].e_idx));
            chk($sformatf("v%0d_full", i), 64'(disp_full), 64'(vecs[i].e_full));
            chk($sformatf("v%0d_iss", i), 64'(issue_vld), 64'(vecs[i].e_iss));
            if (vecs[i].e_iss) begin
                chk($sformatf("v%0d_addr", i), 64'(issue_entry.addr), 64'(vecs[i].e_addr));
                chk($sformatf("v%0d_mk", i), 64'(issue_entry.sdq_marker), 64'(vecs[i].e_mk));
                chk($sformatf("v%0d_lidx", i), 64'(issue_entry.ldq_idx), 64'(vecs[i].e_lidx));
                chk($sformatf("v%0d_avld", i), 64'(issue_entry.addr_vld), 1);
            end else begin
                chk($sformatf("v%0d_zero", i), 64'(issue_entry), 0);
            end
        end

        // Head is slot 4 (no address yet), tail at 5: fill the remaining 15 slots across the wrap.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            drive(1, (5 + k) % 16, 0, 0, 0);
            #1;
            chk($sformatf("fill%0d_idx", k), 64'(disp_ldq_idx), 64'((5 + k) % 16));
            chk($sformatf("fill%0d_full", k), 64'(disp_full), 0);
        end
        @(negedge clk);
        drive(1, 'h1F, 0, 0, 0);
        #1;
        chk("full_set", 64'(disp_full), 1);
        chk("full_idx", 64'(disp_ldq_idx), 4);
        @(negedge clk);
        drive(0, 0, 1, 4, 'hAAA0);
        #1;
        chk("full_ignored_idx", 64'(disp_ldq_idx), 4);
        chk("full_ignored_full", 64'(disp_full), 1);
        chk("full_exec_noiss", 64'(issue_vld), 0);
        @(negedge clk);
        drive(1, 'h1E, 0, 0, 0);
        #1;
        chk("full_iss_vld", 64'(issue_vld), 1);
        chk("full_iss_addr", 64'(issue_entry.addr), 'hAAA0);
        chk("full_iss_mk", 64'(issue_entry.sdq_marker), 1);
        chk("full_iss_still_full", 64'(disp_full), 1);
        @(negedge clk);
        drive(1, 'h1E, 0, 0, 0);
        #1;
        chk("refill_full", 64'(disp_full), 0);
        chk("refill_idx", 64'(disp_ldq_idx), 4);

        // Addresses arrive head-first one per cycle; issues must trail by exactly one cycle.
        for (int j = 0; j <= 16; j++) begin
            automatic int eidx = (5 + j) % 16;
            automatic int pidx = (5 + j - 1) % 16;
            @(negedge clk);
            if (j < 16) drive(0, 0, 1, eidx, 'h1000 + eidx * 16);
            else        drive(0, 0, 0, 0, 0);
            #1;
            if (j == 0) begin
                chk("drain0_iss", 64'(issue_vld), 0);
                chk("drain0_full", 64'(disp_full), 1);
            end else begin
                chk($sformatf("drain%0d_iss", j), 64'(issue_vld), 1);
                chk($sformatf("drain%0d_lidx", j), 64'(issue_entry.ldq_idx), 64'(pidx));
                chk($sformatf("drain%0d_addr", j), 64'(issue_entry.addr), 64'('h1000 + pidx * 16));
                chk($sformatf("drain%0d_mk", j), 64'(issue_entry.sdq_marker),
                    64'((pidx == 4) ? 'h1E : pidx));
            end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        chk("empty_iss", 64'(issue_vld), 0);
        chk("empty_full", 64'(disp_full), 0);
        chk("empty_idx", 64'(disp_ldq_idx), 5);
        chk("empty_entry", 64'(issue_entry), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
